// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store atomic initiator.
//   - bus width defaults (DATA_W, ADDR_W)
//   - request op codes (OP_LW .. OP_CAS); codes above OP_CAS are illegal
//   - FSM state type for lsu_atomic_ctrl
//   - op_legal(): legality decode for a request op code
package lsu_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned ADDR_W = 32;

   localparam logic [2:0] OP_LW   = 3'b000;
   localparam logic [2:0] OP_SW   = 3'b001;
   localparam logic [2:0] OP_SWAP = 3'b010;
   localparam logic [2:0] OP_FADD = 3'b011;
   localparam logic [2:0] OP_CAS  = 3'b100;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_MODIFY = 2'd2,
      ST_RESP   = 2'd3
   } lsu_state_t;

   function automatic logic op_legal(input logic [2:0] op);
      return (op <= OP_CAS);
   endfunction

endpackage

// File: rtl/lsu_amo_alu.sv
// lsu_amo_alu: combinational modify stage of an atomic read-modify-write.
//   op      in  request op code (only SWAP/FADD/CAS produce a write)
//   old     in  value read from memory in the access cycle
//   wdata   in  swap value, addend or CAS new value
//   cmp     in  CAS compare value
//   new_val out value to write back (0 when no write)
//   wr_en   out write-back enable
module lsu_amo_alu #(
   parameter int unsigned DATA_W = lsu_pkg::DATA_W
) (
   input  logic [2:0]        op,
   input  logic [DATA_W-1:0] old,
   input  logic [DATA_W-1:0] wdata,
   input  logic [DATA_W-1:0] cmp,
   output logic [DATA_W-1:0] new_val,
   output logic              wr_en
);
   import lsu_pkg::*;

   always_comb begin
      new_val = '0;
      wr_en   = 1'b0;
      case (op)
         OP_SWAP: begin
            new_val = wdata;
            wr_en   = 1'b1;
         end
         OP_FADD: begin
            // wraps modulo 2^DATA_W, carry dropped
            new_val = old + wdata;
            wr_en   = 1'b1;
         end
         OP_CAS: begin
            if (old == cmp) begin
               new_val = wdata;
               wr_en   = 1'b1;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/lsu_atomic_ctrl.sv
// lsu_atomic_ctrl: multi-cycle load/store/atomic initiator between the core
// and a dmem-style memory (combinational read, write on clk rise when
// mem_we or mem_atomic is high).
//   clk, reset_n           clock, asynchronous active-low reset
//   req_valid/req_ready    request handshake (ready only in IDLE)
//   req_op/addr/wdata/cmp  request fields, latched at accept
//   resp_valid/rdata/err   one-cycle response pulse
//   mem_we/mem_atomic      plain / atomic write strobes
//   mem_addr/mem_wd/mem_rd memory address, write data, read data
// All outputs decode from the registered state and request latches only.
module lsu_atomic_ctrl #(
   parameter int unsigned ADDR_W = lsu_pkg::ADDR_W,
   parameter int unsigned DATA_W = lsu_pkg::DATA_W
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [2:0]        req_op,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic [DATA_W-1:0] req_cmp,
   output logic              resp_valid,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              resp_err,
   output logic              mem_we,
   output logic              mem_atomic,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wd,
   input  logic [DATA_W-1:0] mem_rd
);
   import lsu_pkg::*;

   lsu_state_t        state_q, state_d;
   logic [2:0]        op_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] cmp_q;
   logic [DATA_W-1:0] rdata_q;
   logic              err_q;
   logic              accept;
   logic              req_err;
   logic [DATA_W-1:0] alu_new;
   logic              alu_we;

   assign accept  = (state_q == ST_IDLE) && req_valid;
   assign req_err = (req_addr[1:0] != 2'b00) || !op_legal(req_op);

   // state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   // next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (req_valid) state_d = req_err ? ST_RESP : ST_ACCESS;
         end
         ST_ACCESS: begin
            if ((op_q == OP_LW) || (op_q == OP_SW)) state_d = ST_RESP;
            else                                    state_d = ST_MODIFY;
         end
         ST_MODIFY: state_d = ST_RESP;
         ST_RESP:   state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // request latches and read capture
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         op_q    <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         cmp_q   <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         if (accept) begin
            op_q    <= req_op;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            cmp_q   <= req_cmp;
            err_q   <= req_err;
         end
         // LW data and the atomic "old" value share one register
         if ((state_q == ST_ACCESS) && (op_q != OP_SW)) rdata_q <= mem_rd;
      end
   end

   lsu_amo_alu #(.DATA_W(DATA_W)) u_amo_alu (
      .op      (op_q),
      .old     (rdata_q),
      .wdata   (wdata_q),
      .cmp     (cmp_q),
      .new_val (alu_new),
      .wr_en   (alu_we)
   );

   // output decode
   always_comb begin
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      resp_rdata = '0;
      resp_err   = 1'b0;
      mem_we     = 1'b0;
      mem_atomic = 1'b0;
      mem_wd     = '0;
      mem_addr   = addr_q;
      case (state_q)
         ST_IDLE: req_ready = 1'b1;
         ST_ACCESS: begin
            if (op_q == OP_SW) begin
               mem_we = 1'b1;
               mem_wd = wdata_q;
            end
         end
         ST_MODIFY: begin
            if (alu_we) begin
               mem_atomic = 1'b1;
               mem_wd     = alu_new;
            end
         end
         ST_RESP: begin
            resp_valid = 1'b1;
            resp_err   = err_q;
            if (!err_q && (op_q != OP_SW)) resp_rdata = rdata_q;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_lsu_atomic_ctrl.sv
module tb_lsu_atomic_ctrl;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  req_op;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [31:0] req_cmp;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        mem_we;
   logic        mem_atomic;
   logic [31:0] mem_addr;
   logic [31:0] mem_wd;
   logic [31:0] mem_rd;

   int errors = 0;
   int checks = 0;

   int we_cnt = 0;
   int at_cnt = 0;
   int both_cnt = 0;
   int resp_cnt = 0;

   logic [31:0] mem [0:63];

   always #5 clk = ~clk;

   lsu_atomic_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_op     (req_op),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_cmp    (req_cmp),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .mem_we     (mem_we),
      .mem_atomic (mem_atomic),
      .mem_addr   (mem_addr),
      .mem_wd     (mem_wd),
      .mem_rd     (mem_rd)
   );

   // dmem-style memory: combinational read, write on rising edge
   assign mem_rd = mem[mem_addr[7:2]];
   always @(posedge clk) begin
      if (mem_we || mem_atomic) mem[mem_addr[7:2]] <= mem_wd;
   end

   always @(negedge clk) begin
      if (mem_we)                we_cnt++;
      if (mem_atomic)            at_cnt++;
      if (mem_we && mem_atomic)  both_cnt++;
      if (resp_valid)            resp_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Issue one request and wait (bounded) for its response.
   // lat = cycles from accept edge to the sampled response; 99 on timeout.
   task automatic issue(input logic [2:0] op, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] cm,
                        output int lat, output logic [31:0] rd, output logic er);
      lat = 99;
      rd  = 'x;
      er  = 1'bx;
      @(negedge clk);
      req_valid = 1'b1;
      req_op    = op;
      req_addr  = addr;
      req_wdata = wd;
      req_cmp   = cm;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         if (resp_valid) begin
            lat = i;
            rd  = resp_rdata;
            er  = resp_err;
            break;
         end
      end
   endtask

   int          lat;
   logic [31:0] rd;
   logic        er;
   int          we0, at0, rs0;
   int          acc [0:2];
   logic [31:0] rsp [0:2];
   int          k, nresp, busy;

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 32'h0;
      reset_n   = 1'b0;
      req_valid = 1'b0;
      req_op    = 3'b000;
      req_addr  = '0;
      req_wdata = '0;
      req_cmp   = '0;

      // reset state
      #12;
      chk("rst_ready",  {31'b0, req_ready},  32'd1);
      chk("rst_rvalid", {31'b0, resp_valid}, 32'd0);
      chk("rst_err",    {31'b0, resp_err},   32'd0);
      chk("rst_rdata",  resp_rdata,          32'd0);
      chk("rst_we",     {31'b0, mem_we},     32'd0);
      chk("rst_atomic", {31'b0, mem_atomic}, 32'd0);
      chk("rst_addr",   mem_addr,            32'd0);
      chk("rst_wd",     mem_wd,              32'd0);
      @(negedge clk);
      reset_n = 1'b1;

      // SW then LW
      we0 = we_cnt;
      issue(3'b001, 32'h10, 32'hDEADBEEF, 32'h0, lat, rd, er);
      chk("sw_lat",   lat,               32'd2);
      chk("sw_rdata", rd,                32'd0);
      chk("sw_err",   {31'b0, er},       32'd0);
      chk("sw_we1",   we_cnt - we0,      32'd1);
      chk("sw_mem",   mem[4],            32'hDEADBEEF);
      issue(3'b000, 32'h10, 32'h0, 32'h0, lat, rd, er);
      chk("lw_lat",   lat,               32'd2);
      chk("lw_rdata", rd,                32'hDEADBEEF);
      chk("lw_err",   {31'b0, er},       32'd0);

      // FADD wrap-around
      issue(3'b001, 32'h20, 32'hFFFFFFFF, 32'h0, lat, rd, er);
      at0 = at_cnt; we0 = we_cnt;
      issue(3'b011, 32'h20, 32'h2, 32'h0, lat, rd, er);
      chk("fadd_lat",   lat,          32'd3);
      chk("fadd_rdata", rd,           32'hFFFFFFFF);
      chk("fadd_mem",   mem[8],       32'h1);
      chk("fadd_at1",   at_cnt - at0, 32'd1);
      chk("fadd_we0",   we_cnt - we0, 32'd0);

      // CAS hit, then CAS miss
      issue(3'b001, 32'h24, 32'h7, 32'h0, lat, rd, er);
      at0 = at_cnt;
      issue(3'b100, 32'h24, 32'h9, 32'h7, lat, rd, er);
      chk("cas_hit_lat",   lat,          32'd3);
      chk("cas_hit_rdata", rd,           32'h7);
      chk("cas_hit_mem",   mem[9],       32'h9);
      chk("cas_hit_at1",   at_cnt - at0, 32'd1);
      at0 = at_cnt;
      issue(3'b100, 32'h24, 32'h33, 32'h7, lat, rd, er);
      chk("cas_miss_rdata", rd,           32'h9);
      chk("cas_miss_mem",   mem[9],       32'h9);
      chk("cas_miss_at0",   at_cnt - at0, 32'd0);

      // misaligned address and illegal op
      we0 = we_cnt; at0 = at_cnt;
      issue(3'b000, 32'h22, 32'h0, 32'h0, lat, rd, er);
      chk("mis_lat",   lat,         32'd1);
      chk("mis_err",   {31'b0, er}, 32'd1);
      chk("mis_rdata", rd,          32'd0);
      issue(3'b101, 32'h30, 32'h5, 32'h0, lat, rd, er);
      chk("ill_lat",   lat,          32'd1);
      chk("ill_err",   {31'b0, er},  32'd1);
      chk("ill_rdata", rd,           32'd0);
      chk("err_nowr",  (we_cnt - we0) + (at_cnt - at0), 32'd0);
      chk("ill_mem",   mem[12],      32'd0);

      // SWAP with reset during MODIFY
      issue(3'b001, 32'h28, 32'h11, 32'h0, lat, rd, er);
      @(negedge clk);
      at0 = at_cnt; rs0 = resp_cnt;
      req_valid = 1'b1; req_op = 3'b010; req_addr = 32'h28; req_wdata = 32'h22;
      @(posedge clk); #1; req_valid = 1'b0;   // ACCESS
      @(posedge clk); #1;                      // MODIFY
      chk("swap_mod_atomic", {31'b0, mem_atomic}, 32'd1);
      reset_n = 1'b0;
      #1;
      chk("swrst_atomic", {31'b0, mem_atomic}, 32'd0);
      chk("swrst_we",     {31'b0, mem_we},     32'd0);
      chk("swrst_wd",     mem_wd,              32'd0);
      chk("swrst_addr",   mem_addr,            32'd0);
      chk("swrst_rvalid", {31'b0, resp_valid}, 32'd0);
      chk("swrst_ready",  {31'b0, req_ready},  32'd1);
      @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("swrst_mem",   mem[10],         32'h11);
      chk("swrst_noat",  at_cnt - at0,    32'd0);
      chk("swrst_nresp", resp_cnt - rs0,  32'd0);

      // SW with reset during ACCESS
      issue(3'b001, 32'h2C, 32'h44, 32'h0, lat, rd, er);
      @(negedge clk);
      we0 = we_cnt;
      req_valid = 1'b1; req_op = 3'b001; req_addr = 32'h2C; req_wdata = 32'h55;
      @(posedge clk); #1; req_valid = 1'b0;   // ACCESS
      reset_n = 1'b0;
      #1;
      chk("swacc_we", {31'b0, mem_we}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("swacc_mem", mem[11],       32'h44);
      chk("swacc_nowe", we_cnt - we0, 32'd0);

      // back-to-back with req_valid held: LW, LW, SWAP
      issue(3'b001, 32'h40, 32'hA1, 32'h0, lat, rd, er);
      issue(3'b001, 32'h44, 32'hB2, 32'h0, lat, rd, er);
      issue(3'b001, 32'h48, 32'hC3, 32'h0, lat, rd, er);
      for (int i = 0; i < 3; i++) begin acc[i] = -1; rsp[i] = 'x; end
      k = 0; nresp = 0; busy = 0;
      @(negedge clk);
      req_valid = 1'b1; req_op = 3'b000; req_addr = 32'h40; req_wdata = 32'h0;
      for (int c = 0; c < 12; c++) begin
         if (c > 0) @(negedge clk);
         if (resp_valid && nresp < 3) begin rsp[nresp] = resp_rdata; nresp++; end
         if (!req_ready && c < 10) busy++;
         if (req_ready && k < 3) begin
            acc[k] = c;
            k++;
            @(posedge clk); #1;
            case (k)
               1: begin req_op = 3'b000; req_addr = 32'h44; end
               2: begin req_op = 3'b010; req_addr = 32'h48; req_wdata = 32'hD4; end
               default: req_valid = 1'b0;
            endcase
         end
      end
      req_valid = 1'b0;
      chk("b2b_acc0", acc[0], 32'd0);
      chk("b2b_acc1", acc[1], 32'd3);
      chk("b2b_acc2", acc[2], 32'd6);
      chk("b2b_busy", busy,   32'd7);
      chk("b2b_nresp", nresp, 32'd3);
      chk("b2b_r0", rsp[0], 32'hA1);
      chk("b2b_r1", rsp[1], 32'hB2);
      chk("b2b_r2", rsp[2], 32'hC3);
      chk("b2b_mem", mem[18], 32'hD4);

      chk("we_atomic_excl", both_cnt, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
